// File: rtl/param_universal_shift_register.sv
// WIDTH-bit universal shift register: hold, shift right/left, parallel load, shift counter.
// Optional rotate on shifts when USR_ROTATE_EN is defined.
module param_universal_shift_register #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              CW        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             si_r,
   input  logic             si_l,
   input  logic             rot,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             so_r,
   output logic             so_l,
   output logic [CW-1:0]    cnt,
   output logic             done
);

   localparam logic [CW-1:0] CMAX = CW'(WIDTH);

   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_cnt;
   logic             w_in_r;
   logic             w_in_l;
   logic             w_shift;

`ifdef USR_ROTATE_EN
   assign w_in_r = rot ? r_q[0]       : si_r;
   assign w_in_l = rot ? r_q[WIDTH-1] : si_l;
`else
   logic w_unused;
   assign w_unused = rot;
   assign w_in_r   = si_r;
   assign w_in_l   = si_l;
`endif

   assign w_shift = en & (mode[1] ^ mode[0]);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_q <= RESET_VAL;
      end else if (en) begin
         case (mode)
            2'b00: r_q <= r_q;
            2'b01: r_q <= {w_in_r, r_q[WIDTH-1:1]};
            2'b10: r_q <= {r_q[WIDTH-2:0], w_in_l};
            2'b11: r_q <= d;
         endcase
      end
   end

   // Load clears, shifts count up and stick at WIDTH
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (en && mode == 2'b11) begin
         r_cnt <= '0;
      end else if (w_shift && r_cnt != CMAX) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign q    = r_q;
   assign so_r = r_q[0];
   assign so_l = r_q[WIDTH-1];
   assign cnt  = r_cnt;
   assign done = (r_cnt == CMAX);

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed-vector bench for param_universal_shift_register (WIDTH=4).
// A second instance checks a non-zero RESET_VAL.
module tb_param_universal_shift_register;

   logic       clk = 1'b0;
   logic       rstn;
   logic       en;
   logic [1:0] mode;
   logic       si_r;
   logic       si_l;
   logic       rot;
   logic [3:0] d;
   logic [3:0] q, q9;
   logic       so_r, so_l, so_r9, so_l9;
   logic [2:0] cnt, cnt9;
   logic       done, done9;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   param_universal_shift_register #(.WIDTH(4), .RESET_VAL(4'b0000)) u_dut (
      .clk(clk), .rstn(rstn), .en(en), .mode(mode),
      .si_r(si_r), .si_l(si_l), .rot(rot), .d(d),
      .q(q), .so_r(so_r), .so_l(so_l), .cnt(cnt), .done(done)
   );

   param_universal_shift_register #(.WIDTH(4), .RESET_VAL(4'b1001)) u_dut9 (
      .clk(clk), .rstn(rstn), .en(en), .mode(mode),
      .si_r(si_r), .si_l(si_l), .rot(rot), .d(d),
      .q(q9), .so_r(so_r9), .so_l(so_l9), .cnt(cnt9), .done(done9)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic [1:0] m,
                        input logic sr, input logic sl,
                        input logic r, input logic [3:0] dd);
      @(negedge clk);
      en = e; mode = m; si_r = sr; si_l = sl; rot = r; d = dd;
   endtask

   logic [3:0] v_bits;
   logic [3:0] v_so;
   logic [3:0] v_q3;
   logic [2:0] v_c3;

   initial begin
      rstn = 1'b0; en = 1'b0; mode = 2'b00;
      si_r = 1'b0; si_l = 1'b0; rot = 1'b0; d = 4'h0;
      #12;
      chk("rst_q", q, 4'b0000);
      chk("rst_cnt", cnt, 0);
      chk("rst_done", done, 0);
      chk("rv_q", q9, 4'b1001);
      chk("rv_so_r", so_r9, 1);
      chk("rv_so_l", so_l9, 1);

      @(negedge clk);
      rstn = 1'b1;

      // shift right 1,0,1,1 (first bit applied first)
      v_bits = 4'b1101;
      v_so   = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         drive(1, 2'b01, v_bits[i], 1'b0, 0, 4'h0);
         step();
         chk("sr_so_r", so_r, v_so[i]);
         chk("sr_cnt", cnt, i + 1);
      end
      chk("sr_q", q, 4'b1101);
      chk("sr_done", done, 1);

      drive(1, 2'b11, 0, 0, 0, 4'b1010);
      step();
      chk("ld_q", q, 4'b1010);
      chk("ld_cnt", cnt, 0);
      chk("ld_done", done, 0);

      drive(1, 2'b10, 1'b1, 1'b1, 0, 4'h0);
      step();
      chk("sl_q", q, 4'b0101);
      chk("sl_so_l", so_l, 0);
      chk("sl_cnt", cnt, 1);

      drive(1, 2'b11, 0, 0, 0, 4'b1010);
      step();
      v_q3 = 4'b1010;
      for (int i = 0; i < 6; i++) begin
         drive(1, 2'b01, 1'b0, 1'b1, 0, 4'h0);
         step();
         v_q3 = {1'b0, v_q3[3:1]};
         v_c3 = (i < 3) ? 3'(i + 1) : 3'd4;
         chk("sat_q", q, v_q3);
         chk("sat_cnt", cnt, v_c3);
      end
      chk("sat_done", done, 1);

      drive(1, 2'b11, 0, 0, 0, 4'b0110);
      step();
      chk("reld_cnt", cnt, 0);
      chk("reld_done", done, 0);
      chk("reld_q", q, 4'b0110);

      drive(1, 2'b01, 1, 0, 0, 4'h0);
      step();
      chk("mix_r_q", q, 4'b1011);
      drive(1, 2'b10, 1, 0, 0, 4'h0);
      step();
      chk("mix_l_q", q, 4'b0110);
      chk("mix_cnt", cnt, 2);

      for (int i = 0; i < 3; i++) begin
         drive(0, 2'b01, 1, 1, 0, 4'hF);
         step();
         chk("en0_q", q, 4'b0110);
         chk("en0_cnt", cnt, 2);
      end

      drive(1, 2'b00, 1, 1, 0, 4'hF);
      step();
      chk("m00_q", q, 4'b0110);
      chk("m00_cnt", cnt, 2);

      drive(1, 2'b01, 1, 0, 0, 4'h0);
      step();
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_q", q, 4'b0000);
      chk("arst_cnt", cnt, 0);
      chk("arst_rv", q9, 4'b1001);
      @(negedge clk);
      rstn = 1'b1;
      en = 1'b0;
      step();
      chk("arel_q", q, 4'b0000);

      drive(1, 2'b11, 0, 0, 0, 4'b1000);
      step();
      drive(1, 2'b01, 0, 0, 1, 4'h0);
      step();
      chk("rot_r0_q", q, 4'b0100);

      drive(1, 2'b11, 0, 0, 0, 4'b1000);
      step();
      drive(1, 2'b01, 1, 0, 1, 4'h0);
      step();
`ifdef USR_ROTATE_EN
      chk("rot_r1_q", q, 4'b0100);
`else
      chk("rot_r1_q", q, 4'b1100);
`endif
      chk("rot_cnt", cnt, 1);

      drive(1, 2'b11, 0, 0, 0, 4'b1000);
      step();
      drive(1, 2'b10, 0, 0, 1, 4'h0);
      step();
`ifdef USR_ROTATE_EN
      chk("rot_l_q", q, 4'b0001);
`else
      chk("rot_l_q", q, 4'b0000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
